// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-LED PWM fader sitting behind the LED PIO out_port.
// Each LED ramps its brightness level one step per step_tick toward its
// on/off target, and the level is turned into a PWM duty on led_out.
module led_fade_pwm #(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              enable,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int unsigned         DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_LVL  = {PWM_BITS{1'b1}};
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [N_LEDS-1:0]   POLARITY = {N_LEDS{ACTIVE_LOW}};

  logic [N_LEDS-1:0]   pattern_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                step_tick;
  logic [PWM_BITS-1:0] level [N_LEDS];
  logic [N_LEDS-1:0]   on_vec;
  logic [N_LEDS-1:0]   pending;

  // Tick fires on the last count of the divider; never while disabled.
  assign step_tick = enable && (div_cnt == DIV_LAST);

  // Input stage: all fade decisions use the registered pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_in;
    end
  end

  // Free-running PWM carrier; wraps naturally at MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Step divider; parked at 0 while disabled so re-enable starts a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!enable || step_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Saturating per-LED brightness ramp toward the target pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        level[i] <= '0;
      end
    end else if (!enable) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        level[i] <= '0;
      end
    end else if (step_tick) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        if (pattern_q[i] && (level[i] != MAX_LVL)) begin
          level[i] <= level[i] + PWM_BITS'(1);
        end else if (!pattern_q[i] && (level[i] != '0)) begin
          level[i] <= level[i] - PWM_BITS'(1);
        end
      end
    end
  end

  // PWM compare and per-LED "not yet at target" flags.
  always_comb begin
    on_vec  = '0;
    pending = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      on_vec[i]  = (level[i] == MAX_LVL) || (level[i] > pwm_cnt);
      pending[i] = pattern_q[i] ? (level[i] != MAX_LVL) : (level[i] != '0);
    end
  end

  // Registered pin drive with optional inversion for active-low boards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= POLARITY;
    end else begin
      led_out <= on_vec ^ POLARITY;
    end
  end

  assign busy = enable & (|pending);

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: four instances with different
// STEP_DIV / ACTIVE_LOW settings share one stimulus stream, a behavioural
// model predicts every cycle's outputs and a monitor compares them.
`timescale 1ns/1ps
module tb_led_fade_pwm;

  localparam int N    = 8;
  localparam int NCFG = 4;
  localparam int MAXL = 15;
  localparam int PER  = 16;

  typedef struct packed {
    logic [NCFG*N-1:0] led;
    logic [NCFG-1:0]   busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] pattern_in;
  logic         enable;
  logic [N-1:0] led_o  [NCFG];
  logic         busy_o [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int unsigned  cyc;
  int unsigned  en_cyc;
  logic [N-1:0] pq;
  int           lvl [NCFG][N];
  logic [N-1:0] led_exp [NCFG];
  exp_t         sb_q [$];

  always #5 clk = ~clk;

  led_fade_pwm #(.N_LEDS(8), .PWM_BITS(4), .STEP_DIV(4), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_o[0]), .busy(busy_o[0]));
  led_fade_pwm #(.N_LEDS(8), .PWM_BITS(4), .STEP_DIV(4), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_o[1]), .busy(busy_o[1]));
  led_fade_pwm #(.N_LEDS(8), .PWM_BITS(4), .STEP_DIV(1), .ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_o[2]), .busy(busy_o[2]));
  led_fade_pwm #(.N_LEDS(8), .PWM_BITS(4), .STEP_DIV(64), .ACTIVE_LOW(1'b0)) dut3 (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_o[3]), .busy(busy_o[3]));

  function automatic int unsigned cfg_div(input int k);
    case (k)
      2:       return 1;
      3:       return 64;
      default: return 4;
    endcase
  endfunction

  function automatic bit cfg_al(input int k);
    return (k == 1);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    cyc    = 0;
    en_cyc = 0;
    pq     = '0;
    for (int k = 0; k < NCFG; k++) begin
      led_exp[k] = cfg_al(k) ? '1 : '0;
      for (int i = 0; i < N; i++) lvl[k][i] = 0;
    end
  endtask

  // One clock of behaviour: brightness L shows for L of every 16 carrier
  // phases, levels move one unit per tick toward the target and saturate.
  task automatic model_step();
    exp_t e;
    int   pwm;
    bit   tick;
    bit   on;
    bit   any_pending;
    pwm = int'(cyc % 32'(PER));
    for (int k = 0; k < NCFG; k++) begin
      tick = enable && ((en_cyc % cfg_div(k)) == cfg_div(k) - 1);
      for (int i = 0; i < N; i++) begin
        on = (lvl[k][i] == MAXL) || (lvl[k][i] > pwm);
        led_exp[k][i] = on ^ cfg_al(k);
      end
      for (int i = 0; i < N; i++) begin
        if (!enable) lvl[k][i] = 0;
        else if (tick) begin
          if (pq[i]) lvl[k][i] = (lvl[k][i] < MAXL) ? lvl[k][i] + 1 : MAXL;
          else       lvl[k][i] = (lvl[k][i] > 0)    ? lvl[k][i] - 1 : 0;
        end
      end
    end
    en_cyc = enable ? en_cyc + 1 : 0;
    cyc    = cyc + 1;
    pq     = pattern_in;
    for (int k = 0; k < NCFG; k++) begin
      any_pending = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (pq[i] ? (lvl[k][i] != MAXL) : (lvl[k][i] != 0)) any_pending = 1'b1;
      end
      e.led[k*N +: N] = led_exp[k];
      e.busy[k]       = enable && any_pending;
    end
    sb_q.push_back(e);
  endtask

  task automatic monitor_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      for (int k = 0; k < NCFG; k++) begin
        chk($sformatf("sb_led_cfg%0d", k), int'(led_o[k]), int'(e.led[k*N +: N]));
        chk($sformatf("sb_busy_cfg%0d", k), int'(busy_o[k]), int'(e.busy[k]));
      end
    end
  endtask

  // Model advances on every clock edge and on asynchronous reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Monitor: compares each post-edge output against the queued prediction.
  always @(posedge clk) begin
    #1;
    if (reset_n === 1'b1) monitor_check();
  end

  task automatic wait_lvl(input int k, input int i, input int tgt, input int budget, input string nm);
    int used;
    used = 0;
    while ((lvl[k][i] != tgt) && (used < budget)) begin
      @(negedge clk);
      used++;
    end
    if (lvl[k][i] != tgt) chk({nm, "_timeout"}, lvl[k][i], tgt);
  endtask

  task automatic wait_busy_low(input int k, input int budget, input string nm);
    int used;
    used = 0;
    while ((busy_o[k] !== 1'b0) && (used < budget)) begin
      @(negedge clk);
      used++;
    end
    chk(nm, int'(busy_o[k]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int other;
    bit seen;
    reset_n    = 1'b0;
    enable     = 1'b1;
    pattern_in = '0;
    repeat (3) @(negedge clk);

    // Reset values, including the inverted instance.
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("reset_led_cfg%0d", k), int'(led_o[k]), cfg_al(k) ? 255 : 0);
      chk($sformatf("reset_busy_cfg%0d", k), int'(busy_o[k]), 0);
    end
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("idle_led_cfg%0d", k), int'(led_o[k]), cfg_al(k) ? 255 : 0);
      chk($sformatf("idle_busy_cfg%0d", k), int'(busy_o[k]), 0);
    end

    // Single LED ramp to full brightness.
    pattern_in = 8'h01;
    seen = 1'b0;
    for (int c = 0; c < 2 && !seen; c++) begin
      @(negedge clk);
      seen = (busy_o[0] === 1'b1);
    end
    chk("busy_rise", int'(seen), 1);
    wait_busy_low(0, 80, "ramp_done_busy");
    @(negedge clk);
    hi = 0;
    other = 0;
    repeat (PER) begin
      @(negedge clk);
      if (led_o[0][0]) hi++;
      if (led_o[0][7:1] != 7'd0) other++;
    end
    chk("full_on_cycles", hi, PER);
    chk("others_dark", other, 0);

    // Duty cycle per level, on the slow instance where levels hold 64 cycles.
    pattern_in = '0;
    reset_n    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hi = 0;
    repeat (PER) begin
      @(negedge clk);
      if (led_o[3][0]) hi++;
    end
    chk("duty_L0", hi, 0);
    pattern_in = 8'h01;
    for (int l = 1; l <= MAXL; l++) begin
      wait_lvl(3, 0, l, 100, $sformatf("duty_wait_L%0d", l));
      hi = 0;
      repeat (PER) begin
        @(negedge clk);
        if (led_o[3][0]) hi++;
      end
      chk($sformatf("duty_L%0d", l), hi, (l == MAXL) ? PER : l);
    end

    // Reversal mid-fade on LED 3.
    pattern_in = 8'h08;
    wait_lvl(0, 3, 7, 60, "rev_up");
    pattern_in = 8'h00;
    wait_busy_low(0, 100, "rev_busy_fall");
    @(negedge clk);
    chk("rev_led_dark", int'(led_o[0]), 0);

    // Enable dropped mid-fade, then re-enabled.
    pattern_in = 8'hFF;
    wait_lvl(0, 0, 9, 80, "en_ramp");
    enable = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) chk($sformatf("dis_busy_cfg%0d", k), int'(busy_o[k]), 0);
    @(negedge clk);
    for (int k = 0; k < NCFG; k++)
      chk($sformatf("dis_led_cfg%0d", k), int'(led_o[k]), cfg_al(k) ? 255 : 0);
    repeat (10) @(negedge clk);
    enable = 1'b1;
    wait_busy_low(0, 80, "reen_busy_fall");
    wait_busy_low(2, 4, "reen_fast_busy_fall");

    // Asynchronous reset pulse mid-ramp, not aligned to any clock edge.
    pattern_in = 8'h55;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("async_led_cfg%0d", k), int'(led_o[k]), cfg_al(k) ? 255 : 0);
      chk($sformatf("async_busy_cfg%0d", k), int'(busy_o[k]), 0);
    end
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_async_led", int'(led_o[0]), 0);
    repeat (30) @(negedge clk);

    // Randomized pattern and enable activity.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) pattern_in = N'($urandom);
      if (enable) begin
        if ($urandom_range(0, 99) < 2) enable = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end
    end
    enable = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
